// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// The oversample constants describe the nominal 16x clock; the receiver scales them to OVERSAMPLE.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int UART_OS_MID    = 7;
    localparam int UART_OS_LAST   = 15;
    localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pad.
// Resets to 1 so the line reads as idle.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            // NOTE: non-blocking so each flop takes the other's old value; blocking would collapse the chain into one stage.
            meta <= rx;
            rx_s <= meta;
        end
    end

endmodule

// File: rtl/uartrx.sv
// 16x-oversampled UART receiver: start, 8 data bits LSB first, optional parity, stop.
// Define UART_RX_PARITY_EN to include the parity bit; otherwise parity_err is tied to 0.
module uartrx
    import uart_pkg::*;
#(
    parameter logic PARITYMODE = 1'b0,
    parameter int   OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] dataout,
    output logic       rdsig,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int                OS_W    = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0]   OS_MID  = OS_W'((UART_OS_MID + 1) * OVERSAMPLE / 16 - 1);
    localparam logic [OS_W-1:0]   OS_LAST = OS_W'((UART_OS_LAST + 1) * OVERSAMPLE / 16 - 1);

    logic                      rx_s;
    rx_state_t                 state;
    logic [OS_W-1:0]           os_cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rx_s (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            os_cnt    <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            dataout   <= '0;
            rdsig     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            // NOTE: rdsig defaults low every cycle so the STOP assignment below yields a single-cycle strobe.
            rdsig  <= 1'b0;
            os_cnt <= os_cnt + 1'b1;
            case (state)
                IDLE: begin
                    os_cnt <= '0;
                    if (!rx_s) begin
                        busy  <= 1'b1;
                        state <= START;
                    end
                end
                START: begin
                    if (os_cnt == OS_MID) begin
                        if (rx_s) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            os_cnt  <= '0;
                            bit_idx <= '0;
                            state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (os_cnt == OS_LAST) begin
                        shreg   <= {rx_s, shreg[UART_DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (os_cnt == OS_LAST) begin
                        parity_err <= ^shreg ^ rx_s ^ PARITYMODE;
                        state      <= STOP;
                    end
                end
`endif
                STOP: begin
                    // Returning at mid-stop lets a closely following start bit be caught.
                    if (os_cnt == OS_LAST) begin
                        dataout   <= shreg;
                        frame_err <= ~rx_s;
                        rdsig     <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uartrx.md
# uartrx

Receive-side companion to `uarttx`: recovers 8-bit characters from a 16x-oversampled asynchronous serial line. Frame is start bit, 8 data bits LSB first, optional parity bit, and stop bit. The block sits between the `rx` pad and the receive FIFO. Its output is a completed byte plus a one-cycle `rdsig` write strobe, with parity and framing error flags. It runs on the same UART clock as `uarttx`, which is 16 clocks per bit.

## Interface
- `PARITYMODE`, default `1'b0`: parity sense. 0 selects even parity, 1 selects odd parity.
- `OVERSAMPLE`, default `16`: clocks per bit. Must be a power of 2 and at least 8.
- `clk` input, 1 bit: UART clock at 16x baud.
- `rst` input, 1 bit: reset. Asynchronous and active-high.
- `rx` input, 1 bit: serial line. It is asynchronous to `clk` and idles high.
- `dataout` output, 8 bits: last received byte. Holds its value until the next frame completes.
- `rdsig` output, 1 bit: one-cycle pulse when `dataout` and the error flags update.
- `parity_err` output, 1 bit: parity mismatch on the last frame. Valid with `rdsig` and held until the next frame.
- `frame_err` output, 1 bit: stop bit was sampled low on the last frame. Valid with `rdsig` and held until the next frame.
- `busy` output, 1 bit: high from start-bit detection until the frame ends or is aborted.

## Operation
- **Synchronizer:** `rx` passes through 2 flops to produce `rx_s`. Both flops reset to 1.
- **State machine:** states are IDLE, START, DATA, PARITY, STOP.
  - The oversample counter `os_cnt` is 4 bits and wraps.
  - The bit index `bit_idx` is 3 bits.
- **IDLE:** when `rx_s` is 0, clear `os_cnt`, set `busy` to 1, and go to START.
- **START:** when `os_cnt` is 7 (mid-bit), sample `rx_s`.
  - If the sample is 1, it is a false start: go to IDLE and set `busy` to 0. No `rdsig` is issued.
  - If the sample is 0, clear `os_cnt`, clear `bit_idx`, and go to DATA.
- **DATA:** when `os_cnt` is 15, shift `rx_s` into the shift register, LSB first, and increment `bit_idx`.
  - After bit 7, go to PARITY if `UART_RX_PARITY_EN` is defined, otherwise go to STOP.
- **PARITY:** when `os_cnt` is 15, compute `parity_err` as the XOR of the 8 data bits, the received parity bit, and `PARITYMODE`. Then go to STOP.
- **STOP:** when `os_cnt` is 15, sample the stop bit. Then, on the same edge:
  - `dataout` takes the shift register value.
  - `frame_err` is set to NOT the sampled stop bit.
  - `rdsig` is set to 1.
  - `busy` is set to 0.
  - The state returns to IDLE.
- **Errored frames:** these are still delivered with `rdsig`. The consumer decides whether to discard.
- **After STOP:**
  - If `rx_s` is still 0, for example on a break, IDLE re-detects it as a new start. The START mid-bit check then rejects it unless the line is still low at mid-bit.
  - A low stop bit followed by a line that stays low produces repeated `frame_err` frames with `dataout` equal to 0x00. This is acceptable break behaviour.

## Timing
- **Reset values:** `dataout` is 0, `rdsig` is 0, `parity_err` is 0, `frame_err` is 0, `busy` is 0, and the state is IDLE.
- **Reset mid-frame:** the frame is abandoned with no `rdsig`. Reception resumes on the next falling edge after reset is released.
- **Reference edge t0:** the edge at which IDLE sees `rx_s` equal to 0. This is 2 or 3 clocks after `rx` falls.
- **Sample points:**
  - Start bit is sampled at t0+8.
  - Data bit i is sampled at t0+8+16·(i+1).
  - Parity is sampled at t0+152.
  - Stop is sampled at t0+168, or at t0+152 when parity is compiled out.
- **Result visibility:** `rdsig` is high for exactly the one cycle following the stop-sample edge. `dataout` and the flags are stable from that cycle.
- **Back-to-back frames:** the block returns to IDLE at mid-stop-bit. A following start bit at least 8 clocks after the stop-bit start is caught.
- **Minimum low pulse:** a low pulse shorter than 8 clocks is rejected as a false start. `busy` drops at t0+8.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- **Defined:** the frame is 11 bits and includes the PARITY state. `parity_err` is computed as described in Operation.
- **Undefined:** the frame is 10 bits. The PARITY state and its logic are omitted. `parity_err` is tied to 0. Stop is sampled at t0+152.

## Structure
- **Package `uart_pkg`:**
  - State enum `rx_state_t`, covering IDLE, START, DATA, PARITY, STOP.
  - `UART_OS_MID` = 7.
  - `UART_OS_LAST` = 15.
  - `UART_DATA_BITS` = 8.
- **Sub-module `uart_rx_sync`:** the 2-flop synchronizer, with reset to 1. It outputs `rx_s`.
- **Top level:** everything else stays in `uartrx`.

## Test plan
- **Valid frame:** send 0x55 with correct even parity and a high stop bit. Expect `dataout` = 0x55, one `rdsig` pulse, `parity_err` = 0, `frame_err` = 0, and `busy` low after the pulse.
- **Bad parity:** send 0xA3 with the parity bit inverted. Expect `dataout` = 0xA3 and `parity_err` = 1 together with `rdsig`.
- **Low stop bit:** send 0x0F with the stop bit driven low. Expect `frame_err` = 1 and `dataout` = 0x0F.
- **Glitch rejection:** drive `rx` low for 4 clocks, then high. Expect no `rdsig`, `busy` to pulse and return to 0, and `dataout` unchanged.
- **Back-to-back frames:** send 0xA3, then 0x3C with only an 8-clock stop-to-start gap. Expect two `rdsig` pulses carrying 0xA3 and 0x3C with no errors.
- **Reset mid-frame:** assert `rst` at data bit 4 of 0xFF, then send 0x12. Expect no `rdsig` for the first frame, all outputs at their reset values, and 0x12 received cleanly.
